// File: rtl/mem_pipelined_if.sv
// rtl/mem_pipelined_if.sv - request/response channel bundle for mem_pipelined
interface mem_pipelined_if #(
    parameter int DATA_WIDTH = 32
);
    logic                      i_req_valid;
    logic                      o_req_ready;
    logic                      i_req_write;
    logic [31:0]               i_req_addr;
    logic [DATA_WIDTH-1:0]     i_req_data;
    logic [DATA_WIDTH/8-1:0]   i_req_mask;
    logic                      o_rsp_valid;
    logic                      i_rsp_ready;
    logic [DATA_WIDTH-1:0]     o_rsp_data;
    logic                      o_rsp_write;
    logic                      o_rsp_err;

    modport master (
        output i_req_valid, i_req_write, i_req_addr, i_req_data, i_req_mask, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_write, o_rsp_err
    );

    modport slave (
        input  i_req_valid, i_req_write, i_req_addr, i_req_data, i_req_mask, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_write, o_rsp_err
    );
endinterface

// File: rtl/mem_pipelined.sv
// rtl/mem_pipelined.sv - byte-maskable RAM with credit-controlled in-order response queue
module mem_pipelined #(
    parameter int NUM_BYTES    = 4*1024*1024,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int RSP_DEPTH    = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    mem_pipelined_if.slave  bus
);
    localparam int WB    = DATA_WIDTH / 8;
    localparam int DEPTH = NUM_BYTES / WB;
    localparam int AW    = $clog2(WB);
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(RSP_DEPTH + 1);
    localparam int PW    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int NS    = READ_LATENCY - 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  accept;
    logic                  pop;
    logic                  f_err;
    logic [IW-1:0]         f_idx;
    logic [DATA_WIDTH-1:0] f_mask_bits;
    logic [DATA_WIDTH-1:0] f_data;

    logic                  push_v;
    logic                  push_w;
    logic                  push_e;
    logic [DATA_WIDTH-1:0] push_d;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         qcnt_q, qcnt_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;

    logic [DATA_WIDTH-1:0] q_data [RSP_DEPTH];
    logic [RSP_DEPTH-1:0]  q_write;
    logic [RSP_DEPTH-1:0]  q_err;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credits cover pipeline and queue, so a response always finds a free slot.
    assign bus.o_req_ready = !i_rst && (cnt_q < CW'(RSP_DEPTH));
    assign accept          = bus.i_req_valid && bus.o_req_ready;
    assign bus.o_rsp_valid = (qcnt_q != '0);
    assign pop             = bus.o_rsp_valid && bus.i_rsp_ready;

    assign f_err = (bus.i_req_addr >= 32'(NUM_BYTES));
    assign f_idx = bus.i_req_addr[AW +: IW];

    always_comb begin
        f_mask_bits = '0;
        for (int b = 0; b < WB; b++) begin
            f_mask_bits[8*b +: 8] = {8{bus.i_req_mask[b]}};
        end
        f_data = (bus.i_req_write || f_err) ? '0 : (mem[f_idx] & f_mask_bits);
    end

    always_ff @(posedge i_clk) begin
        if (accept && bus.i_req_write && !f_err) begin
            for (int b = 0; b < WB; b++) begin
                if (bus.i_req_mask[b]) begin
                    mem[f_idx][8*b +: 8] <= bus.i_req_data[8*b +: 8];
                end
            end
        end
    end

    generate
        if (NS == 0) begin : g_direct
            assign push_v = accept;
            assign push_w = bus.i_req_write;
            assign push_e = f_err;
            assign push_d = f_data;
        end else begin : g_pipe
            logic                  sv_q [NS];
            logic                  sw_q [NS];
            logic                  se_q [NS];
            logic [DATA_WIDTH-1:0] sd_q [NS];

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    for (int i = 0; i < NS; i++) begin
                        sv_q[i] <= 1'b0;
                        sw_q[i] <= 1'b0;
                        se_q[i] <= 1'b0;
                    end
                end else begin
                    sv_q[0] <= accept;
                    sw_q[0] <= bus.i_req_write;
                    se_q[0] <= f_err;
                    for (int i = 1; i < NS; i++) begin
                        sv_q[i] <= sv_q[i-1];
                        sw_q[i] <= sw_q[i-1];
                        se_q[i] <= se_q[i-1];
                    end
                end
            end

            always_ff @(posedge i_clk) begin
                sd_q[0] <= f_data;
                for (int i = 1; i < NS; i++) begin
                    sd_q[i] <= sd_q[i-1];
                end
            end

            assign push_v = sv_q[NS-1];
            assign push_w = sw_q[NS-1];
            assign push_e = se_q[NS-1];
            assign push_d = sd_q[NS-1];
        end
    endgenerate

    always_comb begin
        cnt_d    = cnt_q;
        qcnt_d   = qcnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (accept && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!accept && pop) begin
            cnt_d = cnt_q - CW'(1);
        end
        if (push_v && !pop) begin
            qcnt_d = qcnt_q + CW'(1);
        end else if (!push_v && pop) begin
            qcnt_d = qcnt_q - CW'(1);
        end
        if (push_v) begin
            wr_ptr_d = bump(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = bump(rd_ptr_q);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q    <= '0;
            qcnt_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            qcnt_q   <= qcnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_v) begin
            q_data[wr_ptr_q]  <= push_d;
            q_write[wr_ptr_q] <= push_w;
            q_err[wr_ptr_q]   <= push_e;
        end
    end

    // Payload is gated by valid so an empty or freshly reset queue shows zeros.
    assign bus.o_rsp_data  = bus.o_rsp_valid ? q_data[rd_ptr_q]  : '0;
    assign bus.o_rsp_write = bus.o_rsp_valid ? q_write[rd_ptr_q] : 1'b0;
    assign bus.o_rsp_err   = bus.o_rsp_valid ? q_err[rd_ptr_q]   : 1'b0;
endmodule
